key_conditioner: RTL and testbench

Front-end key conditioning stage for the DE1-SOC stopwatch. It takes the raw, active-low push-button inputs (reset, start/pause, display freeze) and feeds the stopwatch core clean, single-cycle event pulses. Per key it performs two-flop synchronisation, a debounce state machine, press/release edge pulses and optional long-press detection. Downstream logic toggles its run and display flags on `key_press` instead of keeping its own ad-hoc key timers.

---
 rtl/key_conditioner.sv | 118 +++++++++++
 tb/tb_key_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-key sync, debounce, press/release/long pulses; long press enabled by KEY_CONDITIONER_LONGPRESS_EN
module key_conditioner #(
    parameter int NUM_KEYS      = 3,
    parameter int DEBOUNCE_TIME = 1000000,
    parameter int LONG_TIME     = 50000000,
    parameter int CNT_W         = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);
    localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_TIME);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    if (DEBOUNCE_TIME < 1 || LONG_TIME < 1) begin : g_bad_param
        $error("key_conditioner: DEBOUNCE_TIME and LONG_TIME must be positive");
    end

    logic [NUM_KEYS-1:0] s1, s2;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level, press, rel;
        logic             pressed;

        assign pressed = ~s2[g];

        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                case (state)
                    IDLE:
                        if (pressed) begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    PRESS_WAIT:
                        if (!pressed) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB) begin
                            state <= PRESSED;
                            level <= 1'b1;
                            press <= 1'b1;
                            cnt   <= '0;
                        end else
                            cnt <= cnt + CNT_W'(1);
                    PRESSED:
                        if (!pressed) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    RELEASE_WAIT:
                        if (pressed)
                            state <= PRESSED;
                        else if (cnt == DB) begin
                            state <= IDLE;
                            level <= 1'b0;
                            rel   <= 1'b1;
                            cnt   <= '0;
                        end else
                            cnt <= cnt + CNT_W'(1);
                    default: state <= IDLE;
                endcase
            end

        assign key_level[g]   = level;
        assign key_press[g]   = press;
        assign key_release[g] = rel;

`ifdef KEY_CONDITIONER_LONGPRESS_EN
        localparam logic [CNT_W-1:0] LT = CNT_W'(LONG_TIME);
        logic [CNT_W-1:0] hold;
        logic             lng;

        // hold keeps counting through RELEASE_WAIT so a bounce does not restart it
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                hold <= '0;
                lng  <= 1'b0;
            end else begin
                lng <= 1'b0;
                if (state == PRESS_WAIT && pressed && cnt == DB)
                    hold <= '0;
                else if ((state == PRESSED || state == RELEASE_WAIT) && hold != LT) begin
                    hold <= hold + CNT_W'(1);
                    lng  <= (hold == LT - CNT_W'(1));
                end
            end

        assign key_long[g] = lng;
`else
        assign key_long[g] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of key_conditioner with DEBOUNCE_TIME=4, LONG_TIME=20
module tb_key_conditioner;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic [2:0] key_level, key_press, key_release, key_long;
    logic [2:0] acc_p, acc_r, acc_l, acc_g;
    int         checks = 0;
    int         errors = 0;

`ifdef KEY_CONDITIONER_LONGPRESS_EN
    localparam logic [2:0] LONG_EXP = 3'b100;
`else
    localparam logic [2:0] LONG_EXP = 3'b000;
`endif

    key_conditioner #(
        .NUM_KEYS(3),
        .DEBOUNCE_TIME(4),
        .LONG_TIME(20),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_n(key_n),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_acc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            acc_p |= key_press;
            acc_r |= key_release;
            acc_l |= key_level;
            acc_g |= key_long;
        end
    endtask

    task automatic clr_acc();
        acc_p = '0;
        acc_r = '0;
        acc_l = '0;
        acc_g = '0;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    initial begin
        // reset with all keys held
        key_n = 3'b000;
        tick(3);
        chk("rst_level", key_level, 3'b000);
        chk("rst_press", key_press, 3'b000);
        chk("rst_release", key_release, 3'b000);
        chk("rst_long", key_long, 3'b000);
        reset_n = 1'b1;
        tick(6);
        chk("rst_press_early", key_press, 3'b000);
        tick(1);
        chk("rst_press_edge6", key_press, 3'b111);
        chk("rst_level_edge6", key_level, 3'b111);
        tick(1);
        chk("rst_press_drop", key_press, 3'b000);
        key_n = 3'b111;
        tick(6);
        chk("rst_rel_early", key_release, 3'b000);
        chk("rst_level_held", key_level, 3'b111);
        tick(1);
        chk("rst_rel_edge6", key_release, 3'b111);
        chk("rst_level_fall", key_level, 3'b000);
        tick(1);
        chk("rst_rel_drop", key_release, 3'b000);
        tick(3);

        // clean press/release on key 1
        key_n = 3'b101;
        tick(6);
        chk("k1_press_early", key_press, 3'b000);
        tick(1);
        chk("k1_press", key_press, 3'b010);
        chk("k1_level", key_level, 3'b010);
        tick(1);
        chk("k1_press_drop", key_press, 3'b000);
        tick(22);
        key_n = 3'b111;
        tick(6);
        chk("k1_rel_early", key_release, 3'b000);
        chk("k1_level_held", key_level, 3'b010);
        tick(1);
        chk("k1_rel", key_release, 3'b010);
        chk("k1_level_fall", key_level, 3'b000);
        tick(1);
        chk("k1_rel_drop", key_release, 3'b000);
        tick(3);

        // bounce rejection on key 0
        clr_acc();
        for (int i = 0; i < 5; i++) begin
            key_n = 3'b110;
            tick_acc(3);
            key_n = 3'b111;
            tick_acc(1);
        end
        tick_acc(8);
        chk("bounce_press", acc_p, 3'b000);
        chk("bounce_level", acc_l, 3'b000);

        // release glitch while pressed
        key_n = 3'b110;
        tick(7);
        chk("glitch_press", key_press, 3'b001);
        clr_acc();
        key_n = 3'b111;
        tick_acc(3);
        key_n = 3'b110;
        tick_acc(8);
        chk("glitch_release", acc_r, 3'b000);
        chk("glitch_level", key_level, 3'b001);
        key_n = 3'b111;
        tick(10);
        chk("glitch_idle", key_level, 3'b000);

        // simultaneous press
        key_n = 3'b000;
        tick(7);
        chk("simul_press", key_press, 3'b111);
        key_n = 3'b111;
        tick(10);
        chk("simul_idle", key_level, 3'b000);

        // staggered press, 2 cycles apart
        key_n = 3'b110;
        tick(2);
        key_n = 3'b100;
        tick(2);
        key_n = 3'b000;
        tick(3);
        chk("stag_k0", key_press, 3'b001);
        tick(1);
        chk("stag_gap0", key_press, 3'b000);
        tick(1);
        chk("stag_k1", key_press, 3'b010);
        tick(1);
        chk("stag_gap1", key_press, 3'b000);
        tick(1);
        chk("stag_k2", key_press, 3'b100);
        chk("stag_level", key_level, 3'b111);
        key_n = 3'b111;
        tick(10);

        // long press on key 2
        key_n = 3'b011;
        tick(7);
        chk("long_press", key_press, 3'b100);
        tick(19);
        chk("long_early", key_long, 3'b000);
        tick(1);
        chk("long_pulse", key_long, LONG_EXP);
        clr_acc();
        tick_acc(13);
        chk("long_once", acc_g, 3'b000);
        key_n = 3'b111;
        tick(10);
        chk("long_idle", key_level, 3'b000);

        // reset in PRESS_WAIT with cnt = 3
        key_n = 3'b110;
        tick(5);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_level", key_level, 3'b000);
        chk("mid_rst_press", key_press, 3'b000);
        reset_n = 1'b1;
        clr_acc();
        tick_acc(6);
        chk("mid_rst_no_early", acc_p, 3'b000);
        tick(1);
        chk("mid_rst_fresh", key_press, 3'b001);
        key_n = 3'b111;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
